// File: rtl/gpio_shift_pkg.sv
// gpio_shift_pkg: state encoding, length-width helper and default sizes for the GPIO shift engine
package gpio_shift_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DIV_WIDTH = 16;
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LATCH, DONE} state_t;
  function automatic int len_w(input int dw);
    return $clog2(dw) + 1;
  endfunction
endpackage

// File: rtl/gpio_shift_if.sv
// gpio_shift_if: control/status and pin bundle, master = GPIO registers/pins, slave = engine; latch_o only with GPIO_SHIFT_LATCH_EN
interface gpio_shift_if import gpio_shift_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DIV_WIDTH = DEF_DIV_WIDTH
) ();
  localparam int LEN_W = len_w(DATA_WIDTH);
  logic start_i;
  logic [LEN_W-1:0] len_i;
  logic msb_first_i;
  logic cpol_i;
  logic [DIV_WIDTH-1:0] div_i;
  logic [DATA_WIDTH-1:0] tx_data_i;
  logic busy_o;
  logic done_o;
  logic [DATA_WIDTH-1:0] rx_data_o;
  logic sclk_o;
  logic sdo_o;
  logic sdi_i;
`ifdef GPIO_SHIFT_LATCH_EN
  logic latch_o;
`endif
  modport master (
    output start_i, len_i, msb_first_i, cpol_i, div_i, tx_data_i, sdi_i,
    input busy_o, done_o, rx_data_o, sclk_o, sdo_o
`ifdef GPIO_SHIFT_LATCH_EN
    , latch_o
`endif
  );
  modport slave (
    input start_i, len_i, msb_first_i, cpol_i, div_i, tx_data_i, sdi_i,
    output busy_o, done_o, rx_data_o, sclk_o, sdo_o
`ifdef GPIO_SHIFT_LATCH_EN
    , latch_o
`endif
  );
endinterface

// File: rtl/gpio_shift_sync.sv
// gpio_shift_sync: two-flop synchroniser (i_d async in, o_q synchronised out, sync reset to 0)
module gpio_shift_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta, r_q;
  always_ff @(posedge clk)
    if (rst) {r_q, r_meta} <= '0;
    else {r_q, r_meta} <= {r_meta, i_d};
  assign o_q = r_q;
endmodule

// File: rtl/gpio_shift_engine.sv
// gpio_shift_engine: full-duplex bit-serial shiftIn/shiftOut engine (clk, rst, bus: gpio_shift_if.slave); GPIO_SHIFT_LATCH_EN adds LATCH phase + latch_o
module gpio_shift_engine import gpio_shift_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
  input logic clk,
  input logic rst,
  gpio_shift_if.slave bus
);
  localparam int LEN_W = len_w(DATA_WIDTH);
  localparam int IDX_W = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_WIDTH);
  state_t r_state, w_next;
  logic [DIV_WIDTH-1:0] r_ph, r_div;
  logic [LEN_W-1:0] r_cnt, r_len, w_len;
  logic [DATA_WIDTH-1:0] r_tx, r_sh, r_rx, w_sh;
  logic [IDX_W-1:0] w_idx;
  logic r_msb, r_cpol, w_sdi, w_last, w_sample;
  gpio_shift_sync u_sync (.clk(clk), .rst(rst), .i_d(bus.sdi_i), .o_q(w_sdi));
  assign w_len = (bus.len_i == '0 || bus.len_i > MAX_LEN) ? MAX_LEN : bus.len_i;
  assign w_last = r_ph == r_div;
  // r_cnt counts remaining bits minus one; tx and rx share the same bit position
  assign w_idx = IDX_W'(r_msb ? r_cnt : r_len - 1'b1 - r_cnt);
  assign w_sample = r_state == HIGH && w_last;
  always_comb begin
    w_sh = r_sh;
    if (w_sample) w_sh[w_idx] = w_sdi;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = bus.start_i ? SETUP : IDLE;
      SETUP: w_next = w_last ? HIGH : SETUP;
`ifdef GPIO_SHIFT_LATCH_EN
      HIGH:  w_next = !w_last ? HIGH : r_cnt != '0 ? SETUP : LATCH;
`else
      HIGH:  w_next = !w_last ? HIGH : r_cnt != '0 ? SETUP : DONE;
`endif
      LATCH: w_next = w_last ? DONE : LATCH;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_ph <= '0;
      r_div <= '0;
      r_cnt <= '0;
      r_len <= '0;
      r_tx <= '0;
      r_sh <= '0;
      r_rx <= '0;
      r_msb <= 1'b0;
      r_cpol <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ph <= w_next != r_state ? '0 : r_ph + 1'b1;
      if (r_state == IDLE && bus.start_i) begin
        r_len <= w_len;
        r_cnt <= w_len - 1'b1;
        r_msb <= bus.msb_first_i;
        r_cpol <= bus.cpol_i;
        r_div <= bus.div_i;
        r_tx <= bus.tx_data_i;
        r_sh <= '0;
      end else begin
        r_sh <= w_sh;
        if (w_sample && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
      if (w_next == DONE) r_rx <= w_sh;
    end
  assign bus.busy_o = r_state inside {SETUP, HIGH, LATCH};
  assign bus.done_o = r_state == DONE;
  assign bus.rx_data_o = r_rx;
  assign bus.sclk_o = r_state == HIGH ? ~r_cpol : r_cpol;
  assign bus.sdo_o = (r_state == SETUP || r_state == HIGH) && r_tx[w_idx];
`ifdef GPIO_SHIFT_LATCH_EN
  assign bus.latch_o = r_state == LATCH;
`endif
endmodule

// File: tb/tb_gpio_shift_engine.sv
// tb_gpio_shift_engine: directed self-checking bench for gpio_shift_engine
module tb_gpio_shift_engine;
`ifdef GPIO_SHIFT_LATCH_EN
  localparam int LX = 1;
`else
  localparam int LX = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  gpio_shift_if #(.DATA_WIDTH(8), .DIV_WIDTH(16)) bus ();
  gpio_shift_engine #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int done_cyc, ndone, rises, seg_min, seg_max, latch_n, latch_first;
  logic [31:0] sdo_bits;
  logic busy1, busy_end, sclk_end;

  task automatic launch(input logic [3:0] len, input logic msb, input logic cpol, input logic [15:0] div, input logic [7:0] tx);
    bus.len_i = len;
    bus.msb_first_i = msb;
    bus.cpol_i = cpol;
    bus.div_i = div;
    bus.tx_data_i = tx;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
  endtask

  task automatic watch(input int limit, input logic cpol, input logic [7:0] sdi_seq, input int start_at);
    logic prev;
    int len, k;
    done_cyc = 0; ndone = 0; rises = 0; sdo_bits = '0; seg_min = 1000000; seg_max = 0;
    latch_n = 0; latch_first = 0; prev = cpol; len = 0; k = 0;
    busy1 = bus.busy_o;
    for (int c = 1; c <= limit; c++) begin
      if (bus.sclk_o != prev) begin
        if (len > 0) begin
          if (len < seg_min) seg_min = len;
          if (len > seg_max) seg_max = len;
        end
        len = 0;
        if (bus.sclk_o != cpol) begin
          rises++;
          sdo_bits = {sdo_bits[30:0], bus.sdo_o};
        end
      end
      if (bus.busy_o) len++;
      if (bus.busy_o && k < 8 && (c == 1 || (bus.sclk_o == cpol && prev != cpol))) begin
        bus.sdi_i = sdi_seq[7-k];
        k++;
      end
      prev = bus.sclk_o;
      if (bus.done_o) begin
        ndone++;
        if (done_cyc == 0) done_cyc = c;
      end
`ifdef GPIO_SHIFT_LATCH_EN
      if (bus.latch_o) begin
        latch_n++;
        if (latch_first == 0) latch_first = c;
      end
`endif
      bus.start_i = (c == start_at);
      busy_end = bus.busy_o;
      sclk_end = bus.sclk_o;
      @(posedge clk);
      #1;
    end
    bus.start_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done_o); end
    checks++; if (bus.rx_data_o !== 8'h00) begin errors++; $display("FAIL reset_rx got %h exp 00", bus.rx_data_o); end
    checks++; if (bus.sclk_o !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b exp 0", bus.sclk_o); end
    checks++; if (bus.sdo_o !== 1'b0) begin errors++; $display("FAIL reset_sdo got %b exp 0", bus.sdo_o); end
`ifdef GPIO_SHIFT_LATCH_EN
    checks++; if (bus.latch_o !== 1'b0) begin errors++; $display("FAIL reset_latch got %b exp 0", bus.latch_o); end
`endif
  endtask

  task automatic test_basic_tx();
    int exp;
    exp = 2 * 8 * 1 + 1 + LX * 1;
    bus.sdi_i = 1'b0;
    launch(4'd8, 1'b1, 1'b0, 16'd0, 8'hA5);
    watch(exp + 3, 1'b0, 8'h00, 0);
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL t1_busy_c1 got %b exp 1", busy1); end
    checks++; if (sdo_bits[7:0] !== 8'hA5) begin errors++; $display("FAIL t1_sdo_seq got %h exp a5", sdo_bits[7:0]); end
    checks++; if (rises !== 8) begin errors++; $display("FAIL t1_rises got %0d exp 8", rises); end
    checks++; if (done_cyc !== exp) begin errors++; $display("FAIL t1_done_cycle got %0d exp %0d", done_cyc, exp); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL t1_ndone got %0d exp 1", ndone); end
    checks++; if (bus.rx_data_o !== 8'h00) begin errors++; $display("FAIL t1_rx got %h exp 00", bus.rx_data_o); end
  endtask

  task automatic test_rx();
    int exp;
    exp = 2 * 8 * 4 + 1 + LX * 4;
    launch(4'd8, 1'b1, 1'b0, 16'd3, 8'h00);
    watch(exp + 3, 1'b0, 8'hC9, 0);
    checks++; if (bus.rx_data_o !== 8'hC9) begin errors++; $display("FAIL t2_rx_msb got %h exp c9", bus.rx_data_o); end
    checks++; if (done_cyc !== exp) begin errors++; $display("FAIL t2_done_cycle got %0d exp %0d", done_cyc, exp); end
    launch(4'd8, 1'b0, 1'b0, 16'd3, 8'h00);
    checks++; if (bus.rx_data_o !== 8'hC9) begin errors++; $display("FAIL t2_rx_hold got %h exp c9", bus.rx_data_o); end
    watch(exp + 3, 1'b0, 8'hC9, 0);
    checks++; if (bus.rx_data_o !== 8'h93) begin errors++; $display("FAIL t2_rx_lsb got %h exp 93", bus.rx_data_o); end
  endtask

  task automatic test_length();
    int exp;
    exp = 2 * 3 * 2 + 1 + LX * 2;
    bus.sdi_i = 1'b1;
    launch(4'd3, 1'b1, 1'b0, 16'd1, 8'hFF);
    watch(exp + 3, 1'b0, 8'hFF, 0);
    checks++; if (rises !== 3) begin errors++; $display("FAIL t3_len3_rises got %0d exp 3", rises); end
    checks++; if (bus.rx_data_o !== 8'h07) begin errors++; $display("FAIL t3_len3_rx got %h exp 07", bus.rx_data_o); end
    checks++; if (done_cyc !== exp) begin errors++; $display("FAIL t3_len3_done got %0d exp %0d", done_cyc, exp); end
    checks++; if (sdo_bits[3:0] !== 4'h7) begin errors++; $display("FAIL t3_len3_sdo got %h exp 7", sdo_bits[3:0]); end
    exp = 2 * 8 * 1 + 1 + LX * 1;
    launch(4'd0, 1'b1, 1'b0, 16'd0, 8'hFF);
    watch(exp + 3, 1'b0, 8'hFF, 0);
    checks++; if (rises !== 8) begin errors++; $display("FAIL t3_len0_rises got %0d exp 8", rises); end
    checks++; if (bus.rx_data_o !== 8'hFF) begin errors++; $display("FAIL t3_len0_rx got %h exp ff", bus.rx_data_o); end
    checks++; if (done_cyc !== exp) begin errors++; $display("FAIL t3_len0_done got %0d exp %0d", done_cyc, exp); end
  endtask

  task automatic test_reset_mid();
    int n;
    bus.sdi_i = 1'b0;
    launch(4'd8, 1'b1, 1'b1, 16'd3, 8'hFF);
    repeat (26) begin @(posedge clk); #1; end
    checks++; if (bus.busy_o !== 1'b1 || bus.sclk_o !== 1'b1 || bus.sdo_o !== 1'b1) begin
      errors++; $display("FAIL t5_pre busy/sclk/sdo got %b%b%b exp 111", bus.busy_o, bus.sclk_o, bus.sdo_o); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL t5_busy got %b exp 0", bus.busy_o); end
    checks++; if (bus.sclk_o !== 1'b0) begin errors++; $display("FAIL t5_sclk got %b exp 0", bus.sclk_o); end
    checks++; if (bus.sdo_o !== 1'b0) begin errors++; $display("FAIL t5_sdo got %b exp 0", bus.sdo_o); end
    checks++; if (bus.rx_data_o !== 8'h00) begin errors++; $display("FAIL t5_rx got %h exp 00", bus.rx_data_o); end
    rst = 1'b0;
    n = 0;
    repeat (80) begin
      if (bus.done_o || bus.busy_o) n++;
      @(posedge clk);
      #1;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL t5_no_done got %0d active cycles exp 0", n); end
  endtask

  task automatic test_cpol_busy_start();
    int exp;
    exp = 2 * 8 * 5 + 1 + LX * 5;
    launch(4'd8, 1'b0, 1'b1, 16'd4, 8'h35);
    watch(exp + 3, 1'b1, 8'h00, 20);
    checks++; if (rises !== 8) begin errors++; $display("FAIL t4_falls got %0d exp 8", rises); end
    checks++; if (seg_min !== 5 || seg_max !== 5) begin errors++; $display("FAIL t4_phase got min %0d max %0d exp 5", seg_min, seg_max); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL t4_ndone got %0d exp 1", ndone); end
    checks++; if (done_cyc !== exp) begin errors++; $display("FAIL t4_done got %0d exp %0d", done_cyc, exp); end
    checks++; if (sdo_bits[7:0] !== 8'hAC) begin errors++; $display("FAIL t4_sdo_lsb got %h exp ac", sdo_bits[7:0]); end
    checks++; if (sclk_end !== 1'b1) begin errors++; $display("FAIL t4_sclk_idle got %b exp 1", sclk_end); end
  endtask

  task automatic test_done_start();
    int exp;
    exp = 2 * 8 * 5 + 1 + LX * 5;
    launch(4'd8, 1'b0, 1'b1, 16'd4, 8'h35);
    watch(exp + 3, 1'b1, 8'h00, exp);
    checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL t7_start_in_done busy got %b exp 0", busy_end); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL t7_ndone got %0d exp 1", ndone); end
  endtask

`ifdef GPIO_SHIFT_LATCH_EN
  task automatic test_latch();
    launch(4'd8, 1'b1, 1'b0, 16'd4, 8'h5A);
    watch(90, 1'b0, 8'h00, 0);
    checks++; if (latch_n !== 5) begin errors++; $display("FAIL t6_latch_len got %0d exp 5", latch_n); end
    checks++; if (latch_first !== 81) begin errors++; $display("FAIL t6_latch_first got %0d exp 81", latch_first); end
    checks++; if (done_cyc !== 86) begin errors++; $display("FAIL t6_done got %0d exp 86", done_cyc); end
  endtask
`endif

  initial begin
    bus.start_i = 1'b0;
    bus.len_i = '0;
    bus.msb_first_i = 1'b0;
    bus.cpol_i = 1'b0;
    bus.div_i = '0;
    bus.tx_data_i = '0;
    bus.sdi_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_basic_tx();
    test_rx();
    test_length();
    test_reset_mid();
    test_cpol_busy_start();
    test_done_start();
`ifdef GPIO_SHIFT_LATCH_EN
    test_latch();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
